// File: rtl/paddle_pkg.sv
// Shared game package: button FSM encoding, scheduler default constants and
// the saturating speed-ramp helper.
package paddle_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_DELAY  = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_e;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned RPT_DELAY_DEF  = 15;
  localparam int unsigned RPT_RATE_DEF   = 4;
  localparam logic [4:0]  SPD_MIN_DEF    = 5'd2;
  localparam logic [4:0]  SPD_STEP_DEF   = 5'd2;
  localparam logic [4:0]  SPD_MAX_DEF    = 5'd16;

  // Repeat counter width; covers delay/rate values up to 255 frame ticks.
  localparam int unsigned RPT_CNT_W      = 8;
  // Frame ticks without a move after which the speed ramp is abandoned.
  localparam int unsigned SPD_IDLE_TICKS = 2;

  // Sum is formed one bit wider than the operands so the saturation compare
  // sees the true value instead of a wrapped one.
  function automatic logic [4:0] spd_next(input logic [4:0] cur,
                                          input logic [4:0] step,
                                          input logic [4:0] max);
    logic [5:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum > {1'b0, max}) return max;
    return sum[4:0];
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small direction FIFO (1-bit entries) for queued rotary steps; a write on a
// full FIFO is accepted only when a read frees a slot in the same cycle.
module dir_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic wr_en,
  input  logic wr_data,
  input  logic rd_en,
  output logic rd_data,
  output logic full,
  output logic empty,
  output logic wr_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             rd_ok;
  logic             wr_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign wr_drop = wr_en && full && !rd_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/paddle_move_sched.sv
// Paddle move scheduler: merges queued rotary steps and button auto-repeat
// into single-cycle move commands with a direction-dependent speed ramp.
//
// state      | meaning
// BTN_IDLE   | no button held, waiting for a press on a frame tick
// BTN_DELAY  | first move issued, counting down to auto-repeat
// BTN_REPEAT | auto-repeating, one move every RPT_RATE ticks
module paddle_move_sched
  import paddle_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_RATE   = RPT_RATE_DEF,
  parameter logic [4:0]  SPD_MIN    = SPD_MIN_DEF,
  parameter logic [4:0]  SPD_STEP   = SPD_STEP_DEF,
  parameter logic [4:0]  SPD_MAX    = SPD_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       frame_tick,
  input  logic       rotary_event,
  input  logic       rotary_right,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       move_event,
  output logic       move_right,
  output logic [4:0] speed,
  output logic       enable,
  output logic       overflow
);

  btn_state_e           state_q, state_d;
  logic [RPT_CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic                 held_q, held_d;
  logic                 pend_q, pend_d;
  logic                 pend_dir_q, pend_dir_d;
  logic                 rr_fifo_q, rr_fifo_d;
  logic                 move_event_q, move_event_d;
  logic                 move_right_q, move_right_d;
  logic [4:0]           speed_q, speed_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [1:0]           idle_ticks_q, idle_ticks_d;
  logic                 enable_q, enable_d;
  logic                 overflow_q, overflow_d;

  logic pressed;
  logic btn_req;
  logic fifo_rd_data;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_drop;
  logic gnt_btn;
  logic gnt_fifo;
  logic grant;
  logic grant_dir;

  // Exactly one button down counts as a press; both or none is a release.
  assign pressed = btn_left ^ btn_right;

  dir_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (!play),
    .wr_en   (play && rotary_event),
    .wr_data (rotary_right),
    .rd_en   (gnt_fifo),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .wr_drop (fifo_drop)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    btn_req = 1'b0;
    cnt_dec = cnt_q - RPT_CNT_W'(1);
    if (!play) begin
      state_d = BTN_IDLE;
      cnt_d   = '0;
    end else if (frame_tick) begin
      case (state_q)
        BTN_IDLE: begin
          if (pressed) begin
            btn_req = 1'b1;
            held_d  = btn_right;
            cnt_d   = RPT_CNT_W'(RPT_DELAY);
            state_d = BTN_DELAY;
          end
        end
        BTN_DELAY, BTN_REPEAT: begin
          // Swapping buttons restarts from IDLE so the new side gets a fresh delay.
          if (!pressed || (btn_right != held_q)) begin
            state_d = BTN_IDLE;
            cnt_d   = '0;
          end else if (cnt_dec == '0) begin
            btn_req = 1'b1;
            cnt_d   = RPT_CNT_W'(RPT_RATE);
            state_d = BTN_REPEAT;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        default: begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Round-robin between the button request and the rotary queue.
  always_comb begin
    gnt_btn   = play && pend_q && (!rr_fifo_q || fifo_empty);
    gnt_fifo  = play && !fifo_empty && !gnt_btn;
    grant     = gnt_btn || gnt_fifo;
    grant_dir = gnt_btn ? pend_dir_q : fifo_rd_data;

    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    rr_fifo_d  = rr_fifo_q;
    if (!play) begin
      pend_d    = 1'b0;
      rr_fifo_d = 1'b0;
    end else begin
      if (gnt_btn)  rr_fifo_d = 1'b1;
      if (gnt_fifo) rr_fifo_d = 1'b0;
      if (btn_req) begin
        pend_d     = 1'b1;
        pend_dir_d = btn_right;
      end else if (gnt_btn) begin
        pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    move_event_d = 1'b0;
    move_right_d = move_right_q;
    speed_d      = speed_q;
    prev_valid_d = prev_valid_q;
    idle_ticks_d = idle_ticks_q;
    enable_d     = play;
    overflow_d   = overflow_q || fifo_drop;
    if (!play) begin
      speed_d      = SPD_MIN;
      prev_valid_d = 1'b0;
      idle_ticks_d = '0;
    end else if (grant) begin
      move_event_d = 1'b1;
      move_right_d = grant_dir;
      prev_valid_d = 1'b1;
      idle_ticks_d = '0;
      if (prev_valid_q && (grant_dir == move_right_q))
        speed_d = spd_next(speed_q, SPD_STEP, SPD_MAX);
      else
        speed_d = SPD_MIN;
    end else if (frame_tick && prev_valid_q) begin
      if (idle_ticks_q == 2'(SPD_IDLE_TICKS - 1)) begin
        prev_valid_d = 1'b0;
        idle_ticks_d = '0;
        speed_d      = SPD_MIN;
      end else begin
        idle_ticks_d = idle_ticks_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= BTN_IDLE;
      cnt_q        <= '0;
      held_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_dir_q   <= 1'b0;
      rr_fifo_q    <= 1'b0;
      move_event_q <= 1'b0;
      move_right_q <= 1'b0;
      speed_q      <= SPD_MIN;
      prev_valid_q <= 1'b0;
      idle_ticks_q <= '0;
      enable_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      held_q       <= held_d;
      pend_q       <= pend_d;
      pend_dir_q   <= pend_dir_d;
      rr_fifo_q    <= rr_fifo_d;
      move_event_q <= move_event_d;
      move_right_q <= move_right_d;
      speed_q      <= speed_d;
      prev_valid_q <= prev_valid_d;
      idle_ticks_q <= idle_ticks_d;
      enable_q     <= enable_d;
      overflow_q   <= overflow_d;
    end
  end

  assign move_event = move_event_q;
  assign move_right = move_right_q;
  assign speed      = speed_q;
  assign enable     = enable_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_paddle_move_sched.sv
// Bench for paddle_move_sched: expected moves are queued as stimulus is
// driven and matched by a monitor; tasks also check timing and flags inline.
module tb_paddle_move_sched;

  logic       clock;
  logic       reset;
  logic       play;
  logic       frame_tick;
  logic       rotary_event;
  logic       rotary_right;
  logic       btn_left;
  logic       btn_right;
  logic       move_event;
  logic       move_right;
  logic [4:0] speed;
  logic       enable;
  logic       overflow;

  int n_tests;
  int n_fail;

  // {direction, speed} of each move still expected from the DUT
  logic [5:0] exp_q[$];

  paddle_move_sched dut (
    .clock        (clock),
    .reset        (reset),
    .play         (play),
    .frame_tick   (frame_tick),
    .rotary_event (rotary_event),
    .rotary_right (rotary_right),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .move_event   (move_event),
    .move_right   (move_right),
    .speed        (speed),
    .enable       (enable),
    .overflow     (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin : monitor
    logic [5:0] e;
    if (!reset && move_event === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_move: got dir=%0b speed=%0d, required no move",
                 move_right, speed);
      end else begin
        e = exp_q.pop_front();
        if ({move_right, speed} !== e) begin
          n_fail++;
          $display("FAIL move_sb: got dir=%0b speed=%0d, required dir=%0b speed=%0d",
                   move_right, speed, e[5], e[4:0]);
        end
      end
    end
  end

  // Apply inputs for one cycle, return #1 after the next rising edge.
  task automatic drive(input logic ft, input logic re, input logic rr,
                       input logic bl, input logic br);
    frame_tick   = ft;
    rotary_event = re;
    rotary_right = rr;
    btn_left     = bl;
    btn_right    = br;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    play  = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Reset asserted with every input active must still win.
  task automatic test_reset();
    reset = 1'b1;
    play  = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0);
    n_tests++;
    if (move_event !== 1'b0) begin
      n_fail++; $display("FAIL reset_move_event: got %0b, required 0", move_event);
    end
    n_tests++;
    if (move_right !== 1'b0) begin
      n_fail++; $display("FAIL reset_move_right: got %0b, required 0", move_right);
    end
    n_tests++;
    if (enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_enable: got %0b, required 0", enable);
    end
    n_tests++;
    if (speed !== 5'd2) begin
      n_fail++; $display("FAIL reset_speed: got %0d, required 2", speed);
    end
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %0b, required 0", overflow);
    end
    reset = 1'b0;
    play  = 1'b0;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_single_rotary();
    do_reset();
    play = 1'b1;
    for (int c = 0; c < 10; c++) drive(0, 0, 0, 0, 0);
    exp_q.push_back({1'b1, 5'd2});
    drive(0, 1, 1, 0, 0);
    n_tests++;
    if (move_event !== 1'b0) begin
      n_fail++; $display("FAIL rotary_latency_early: got %0b at N+1, required 0", move_event);
    end
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({move_event, move_right, speed, enable} !== {1'b1, 1'b1, 5'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL rotary_latency: got ev=%0b dir=%0b spd=%0d en=%0b at N+2, required 1 1 2 1",
               move_event, move_right, speed, enable);
    end
    for (int c = 0; c < 3; c++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_speed_ramp();
    int s;
    do_reset();
    play = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      s = 2 + 2 * i;
      if (s > 16) s = 16;
      drive(1, 0, 0, 0, 0);
      exp_q.push_back({1'b1, 5'(s)});
      drive(0, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0);
    exp_q.push_back({1'b0, 5'd2});
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    exp_q.push_back({1'b0, 5'd4});
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    n_tests++;
    if (speed !== 5'd4) begin
      n_fail++; $display("FAIL speed_hold: got %0d after one idle tick, required 4", speed);
    end
    drive(1, 0, 0, 0, 0);
    n_tests++;
    if (speed !== 5'd2) begin
      n_fail++; $display("FAIL speed_timeout: got %0d after two idle ticks, required 2", speed);
    end
    exp_q.push_back({1'b0, 5'd2});
    drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_button_repeat();
    logic bl;
    logic got;
    logic want;
    do_reset();
    play = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int t = 0; t < 35; t++) begin
      bl   = (t < 30);
      want = (t == 0) || (t == 15) || (t == 19) || (t == 23) || (t == 27);
      if (want) exp_q.push_back({1'b0, 5'd2});
      got = 1'b0;
      drive(1, 0, 0, bl, 0);
      for (int k = 0; k < 3; k++) begin
        drive(0, 0, 0, bl, 0);
        if (move_event === 1'b1) got = 1'b1;
      end
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL btn_repeat_tick%0d: got move=%0b, required %0b", t, got, want);
      end
    end
  endtask

  // Button re-requests every other tick while rotary steps arrive every
  // cycle: grants alternate and the queue eventually overflows.
  task automatic test_arbiter_overflow();
    do_reset();
    play = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 5'd2});
      exp_q.push_back({1'b0, 5'd2});
    end
    exp_q.push_back({1'b0, 5'd4});
    exp_q.push_back({1'b0, 5'd6});
    exp_q.push_back({1'b0, 5'd8});
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, 0, 0, (c % 2 == 0));
      if (c == 6) begin
        n_tests++;
        if (overflow !== 1'b0) begin
          n_fail++; $display("FAIL overflow_early: got %0b before drop, required 0", overflow);
        end
      end
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_set: got %0b, required 1", overflow);
    end
    for (int c = 0; c < 8; c++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    logic bad;
    play = 1'b0;
    drive(0, 0, 0, 0, 0);
    play = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int t = 0; t < 17; t++) begin
      if (t == 0 || t == 15) exp_q.push_back({1'b0, 5'd2});
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
    end
    drive(0, 1, 1, 1, 0);
    play = 1'b0;
    drive(1, 1, 1, 1, 0);
    n_tests++;
    if ({move_event, enable} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_immediate: got ev=%0b en=%0b, required 0 0", move_event, enable);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, c[0], 1, 0);
      if (move_event !== 1'b0) bad = 1'b1;
    end
    play = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1, 0);
      if (move_event !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL flush_quiet: got a move after flush, required none");
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL flush_overflow_kept: got %0b, required 1", overflow);
    end
    exp_q.push_back({1'b0, 5'd2});
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    n_tests++;
    if (move_event !== 1'b1) begin
      n_fail++; $display("FAIL flush_fsm_idle: got move=%0b on first tick, required 1", move_event);
    end
    for (int c = 0; c < 3; c++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    play         = 1'b0;
    frame_tick   = 1'b0;
    rotary_event = 1'b0;
    rotary_right = 1'b0;
    btn_left     = 1'b0;
    btn_right    = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_single_rotary();
    test_speed_ramp();
    test_button_repeat();
    test_arbiter_overflow();
    test_flush();
    test_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d moves never issued, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
